// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the shared memory arbiter: one instance per requester.
// master = requester view, slave = arbiter view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              lock;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (m0 = CPU, m1 = loader) in front of a single-port memory.
// Optional loader ownership lock is enabled with `define MEM_ARBITER_LOCK_EN.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_arbiter_if.slave      m0,
    mem_arbiter_if.slave      m1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  burst_cnt_reg;
    logic              last_owner_reg;
    logic              rd_pend_reg;
    logic              rd_owner_reg;

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];
    logic [BE_W-1:0]   be_arr    [2];

    assign req_vec      = {m1.req, m0.req};
    assign we_vec       = {m1.we, m0.we};
    assign addr_arr[0]  = m0.addr;
    assign addr_arr[1]  = m1.addr;
    assign wdata_arr[0] = m0.wdata;
    assign wdata_arr[1] = m1.wdata;
    assign be_arr[0]    = m0.be;
    assign be_arr[1]    = m1.be;

    logic locked;
    logic unused_lock;
`ifdef MEM_ARBITER_LOCK_EN
    assign locked      = m1.lock & (state_reg == OWN1);
    assign unused_lock = m0.lock;
`else
    assign locked      = 1'b0;
    assign unused_lock = m0.lock ^ m1.lock;
`endif

    // Grant decision; grant_sel stays 0 without a grant so the memory bus defaults to m0.
    logic grant_any;
    logic grant_sel;
    logic same_owner;
    logic own_sel;
    logic own_req;
    logic oth_req;

    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        own_sel   = (state_reg == OWN1);
        own_req   = req_vec[own_sel];
        oth_req   = req_vec[~own_sel];
        case (state_reg)
            IDLE: begin
                if (req_vec[0] && req_vec[1]) begin
                    grant_any = 1'b1;
                    grant_sel = ~last_owner_reg;
                end else if (req_vec[0]) begin
                    grant_any = 1'b1;
                    grant_sel = 1'b0;
                end else if (req_vec[1]) begin
                    grant_any = 1'b1;
                    grant_sel = 1'b1;
                end
            end
            default: begin
                if (locked) begin
                    grant_any = req_vec[1];
                    grant_sel = req_vec[1];
                end else if (own_req && (!oth_req || burst_cnt_reg < CNT_MAX)) begin
                    grant_any = 1'b1;
                    grant_sel = own_sel;
                end else if (oth_req) begin
                    grant_any = 1'b1;
                    grant_sel = ~own_sel;
                end
            end
        endcase
        same_owner = grant_sel ? (state_reg == OWN1) : (state_reg == OWN0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            burst_cnt_reg  <= '0;
            last_owner_reg <= 1'b1;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= 1'b0;
        end else begin
            if (grant_any) begin
                state_reg      <= grant_sel ? OWN1 : OWN0;
                last_owner_reg <= grant_sel;
                if (!same_owner) begin
                    burst_cnt_reg <= CNT_W'(1);
                end else if (burst_cnt_reg != CNT_MAX) begin
                    burst_cnt_reg <= burst_cnt_reg + CNT_W'(1);
                end
            end else if (!locked) begin
                // A locked loader keeps ownership across idle cycles of its sequence.
                state_reg     <= IDLE;
                burst_cnt_reg <= '0;
            end
            rd_pend_reg  <= grant_any & ~we_vec[grant_sel];
            rd_owner_reg <= grant_sel;
        end
    end

    logic [1:0] gnt_vec;
    logic [1:0] rvalid_vec;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign gnt_vec[gi]    = reset_n & grant_any & (grant_sel == 1'(gi));
        assign rvalid_vec[gi] = reset_n & rd_pend_reg & (rd_owner_reg == 1'(gi));
    end

    assign m0.gnt    = gnt_vec[0];
    assign m1.gnt    = gnt_vec[1];
    assign m0.rvalid = rvalid_vec[0];
    assign m1.rvalid = rvalid_vec[1];
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;

    assign mem_en    = reset_n & grant_any;
    assign mem_we    = mem_en & we_vec[grant_sel];
    assign mem_addr  = addr_arr[grant_sel];
    assign mem_wdata = wdata_arr[grant_sel];
    assign mem_be    = be_arr[grant_sel];
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a service-order model of the arbitration rules.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0_bus ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1_bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Model: who was served last cycle (-1 = nobody), how many times in a row, last served port.
    int          owner_m  = -1;
    int          streak_m = 0;
    int          last_m   = 1;
    int          pend_m   = -1;
    logic [31:0] pend_addr;
    int          trace[$];
    int          obs[$];

    logic        s_g0, s_g1, s_en, s_we, s_rv0, s_rv1;
    logic [31:0] s_addr, s_wdata, s_rd0, s_rd1;
    logic [3:0]  s_be;
    logic        rd_strobe;
    logic [31:0] rd_addr;

    function automatic logic [31:0] resp(logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h12345678);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One clock: compare outputs against the model at the falling edge, advance the model,
    // then present memory read data for the next cycle.
    task automatic step();
        int   g;
        int   o;
        bit   r0, r1, ro, rp, locked, we_g;
        @(negedge clk);
        s_g0 = m0_bus.gnt;    s_g1 = m1_bus.gnt;   s_en = mem_en;  s_we = mem_we;
        s_rv0 = m0_bus.rvalid; s_rv1 = m1_bus.rvalid;
        s_rd0 = m0_bus.rdata; s_rd1 = m1_bus.rdata;
        s_addr = mem_addr;    s_wdata = mem_wdata; s_be = mem_be;
        r0 = m0_bus.req;      r1 = m1_bus.req;
        g = -1;
        locked = 1'b0;
        if (reset_n) begin
`ifdef MEM_ARBITER_LOCK_EN
            locked = m1_bus.lock && owner_m == 1;
`endif
            if (locked) begin
                g = r1 ? 1 : -1;
            end else if (owner_m < 0) begin
                if (r0 && r1) g = 1 - last_m;
                else if (r0) g = 0;
                else if (r1) g = 1;
            end else begin
                o  = owner_m;
                ro = (o == 0) ? r0 : r1;
                rp = (o == 0) ? r1 : r0;
                if (ro && (!rp || streak_m < MB)) g = o;
                else if (rp) g = 1 - o;
            end
        end
        we_g = (g == 0) ? m0_bus.we : (g == 1) ? m1_bus.we : 1'b0;
        chk("m0_gnt", s_g0, g == 0);
        chk("m1_gnt", s_g1, g == 1);
        chk("mem_en", s_en, g >= 0);
        chk("mem_we", s_we, we_g);
        if (g >= 0) begin
            chk("mem_addr",  s_addr,  (g == 0) ? m0_bus.addr  : m1_bus.addr);
            chk("mem_wdata", s_wdata, (g == 0) ? m0_bus.wdata : m1_bus.wdata);
            chk("mem_be",    s_be,    (g == 0) ? m0_bus.be    : m1_bus.be);
            $display("txn t=%0t grant m%0d %s addr=%h", $time, g, we_g ? "WR" : "RD",
                     (g == 0) ? m0_bus.addr : m1_bus.addr);
        end
        chk("m0_rvalid", s_rv0, reset_n && pend_m == 0);
        chk("m1_rvalid", s_rv1, reset_n && pend_m == 1);
        if (reset_n && pend_m == 0) chk("m0_rdata", s_rd0, resp(pend_addr));
        if (reset_n && pend_m == 1) chk("m1_rdata", s_rd1, resp(pend_addr));
        trace.push_back(g);
        obs.push_back(s_g1 ? 1 : (s_g0 ? 0 : -1));
        if (!reset_n) begin
            owner_m = -1; streak_m = 0; last_m = 1; pend_m = -1;
        end else begin
            pend_m    = (g >= 0 && !we_g) ? g : -1;
            pend_addr = (g == 1) ? m1_bus.addr : m0_bus.addr;
            if (g < 0) begin
                if (!locked) begin
                    owner_m = -1; streak_m = 0;
                end
            end else begin
                if (g == owner_m) streak_m = (streak_m < MB) ? streak_m + 1 : MB;
                else begin
                    owner_m = g; streak_m = 1;
                end
                last_m = g;
            end
        end
        rd_strobe = s_en && !s_we;
        rd_addr   = s_addr;
        @(posedge clk);
        #1;
        mem_rdata = rd_strobe ? resp(rd_addr) : $urandom;
    endtask

    task automatic set_req(int p, bit r, bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        if (p == 0) begin
            m0_bus.req = r; m0_bus.we = we; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.be = be;
        end else begin
            m1_bus.req = r; m1_bus.we = we; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.be = be;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        chk("rst_m0_gnt", s_g0, 1'b0);
        chk("rst_m1_gnt", s_g1, 1'b0);
        chk("rst_mem_en", s_en, 1'b0);
        step();
        reset_n = 1'b1;
    endtask

    task automatic rand_port(int p, bit gnt_seen);
        bit cur;
        cur = (p == 0) ? m0_bus.req : m1_bus.req;
        if (cur && gnt_seen) cur = 1'b0;
        else if (cur && ($urandom % 16 == 0)) cur = 1'b0;
        if (!cur && ($urandom % 2 == 0)) begin
            set_req(p, 1'b1, 1'($urandom % 2), 32'($urandom_range(0, 255)) << 2, $urandom,
                    4'($urandom));
        end else if (p == 0) begin
            m0_bus.req = cur;
        end else begin
            m1_bus.req = cur;
        end
    endtask

    int exp_cont[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`ifdef MEM_ARBITER_LOCK_EN
    int exp_lock[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`else
    int exp_lock[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
`endif

    initial begin
        reset_n   = 1'b0;
        mem_rdata = '0;
        m0_bus.lock = 1'b0;
        m1_bus.lock = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset with both requesting, then sustained contention.
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        set_req(1, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        do_reset();
        trace.delete();
        obs.delete();
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("cont_model_%0d", i), trace[i], exp_cont[i]);
            chk($sformatf("cont_dut_%0d", i), obs[i], exp_cont[i]);
        end

        // Single read from m0.
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        step();
        chk("single_gnt", s_g0, 1'b1);
        chk("single_addr", s_addr, 32'h100);
        m0_bus.req = 1'b0;
        step();
        chk("single_rvalid", s_rv0, 1'b1);
        chk("single_rdata", s_rd0, 32'hDEADBEEF);
        chk("single_m1_rvalid", s_rv1, 1'b0);

        // Mixed: m0 write against m1 read.
        set_req(0, 1'b1, 1'b1, 32'h20, 32'h0000ABCD, 4'b0011);
        set_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        do_reset();
        step();
        chk("mixed_wr_gnt", s_g0, 1'b1);
        chk("mixed_wr_we", s_we, 1'b1);
        chk("mixed_wr_be", s_be, 4'b0011);
        chk("mixed_wr_data", s_wdata, 32'h0000ABCD);
        m0_bus.req = 1'b0;
        step();
        chk("mixed_rd_gnt", s_g1, 1'b1);
        chk("mixed_rd_we", s_we, 1'b0);
        chk("mixed_rd_no_rv0", s_rv0, 1'b0);
        m1_bus.req = 1'b0;
        step();
        chk("mixed_rv1", s_rv1, 1'b1);
        chk("mixed_rv0", s_rv0, 1'b0);
        chk("mixed_rdata", s_rd1, resp(32'h40));

        // Reset right after an m1 read grant drops the response.
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        do_reset();
        set_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        step();
        chk("midrst_gnt", s_g1, 1'b1);
        reset_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
        step();
        chk("midrst_rv1", s_rv1, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        chk("midrst_tie_m0", s_g0, 1'b1);
        chk("midrst_tie_m1", s_g1, 1'b0);
        step();
        chk("midrst_late_rv1", s_rv1, 1'b0);

        // Loader lock while m1 owns.
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        do_reset();
        m1_bus.lock = 1'b1;
        set_req(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        trace.delete();
        obs.delete();
        step();
        set_req(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("lock_model_%0d", i), trace[i], exp_lock[i]);
            chk($sformatf("lock_dut_%0d", i), obs[i], exp_lock[i]);
        end
        m1_bus.lock = 1'b0;

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom % 400 == 0) reset_n = 1'b0;
            rand_port(0, s_g0);
            rand_port(1, s_g1);
            m1_bus.lock = ($urandom % 4 == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
